// File: rtl/ebaz_led_ctrl.sv
// EBAZ board LED drive: GPIO passthrough, MII activity stretch, heartbeat or off.
// Optional PWM dimming with `define EBAZ_LED_PWM_EN (adds the pwm_duty input).

module ebaz_led_stretch #(
    parameter int STRETCH_MS = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    input  logic ms_tick,
    input  logic clr,
    output logic active
);
    logic       sig_q;
    logic [9:0] cnt;

    // Hold the count while the level is high so the stretch starts at the falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sig_q <= sig;
            if (clr)
                cnt <= '0;
            else if (sig && !sig_q)
                cnt <= 10'(STRETCH_MS);
            else if (ms_tick && !sig && cnt != '0)
                cnt <= cnt - 10'd1;
        end
    end

    assign active = ((cnt != '0) && !clr) || sig;
endmodule

module ebaz_led_ctrl #(
    parameter int CLK_HZ         = 25000000,
    parameter int STRETCH_MS     = 50,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] gpio_led,
    input  logic [1:0] gpio_mode,
    input  logic       mii_tx_en,
    input  logic       mii_rx_dv,
`ifdef EBAZ_LED_PWM_EN
    input  logic [7:0] pwm_duty,
`endif
    output logic       led_red,
    output logic       led_green
);
    localparam int   DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int   PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic INV = (LED_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        M_PASS  = 2'b00,
        M_ACT   = 2'b01,
        M_HEART = 2'b10,
        M_OFF   = 2'b11
    } mode_e;

`ifdef EBAZ_LED_PWM_EN
    localparam int SW = 14;
    logic [SW-1:0] async_in;
    assign async_in = {pwm_duty, mii_rx_dv, mii_tx_en, gpio_mode, gpio_led};
`else
    localparam int SW = 6;
    logic [SW-1:0] async_in;
    assign async_in = {mii_rx_dv, mii_tx_en, gpio_mode, gpio_led};
`endif

    logic [SW-1:0] sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
        end
    end

    logic [1:0] led_s;
    mode_e      mode_s, mode_q;
    logic       tx_s, rx_s;

    assign led_s  = sync2[1:0];
    assign mode_s = mode_e'(sync2[3:2]);
    assign tx_s   = sync2[4];
    assign rx_s   = sync2[5];

    // 1 ms prescaler, free running across mode changes.
    logic [PW-1:0] pre_cnt;
    logic          ms_tick;

    assign ms_tick = (pre_cnt == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_cnt <= '0;
        else if (ms_tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + PW'(1);
    end

    logic mode_chg;
    assign mode_chg = (mode_s != mode_q);

    logic [9:0] hb_ms, hb_eff;
    logic       hb_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= M_PASS;
            hb_ms  <= '0;
        end else begin
            mode_q <= mode_s;
            if (mode_chg)
                hb_ms <= '0;
            else if (ms_tick)
                hb_ms <= (hb_ms == 10'd999) ? 10'd0 : hb_ms + 10'd1;
        end
    end

    // The output update on the detection edge already sees the cleared counters.
    assign hb_eff = mode_chg ? 10'd0 : hb_ms;
    assign hb_on  = (hb_eff < 10'd100) || (hb_eff >= 10'd200 && hb_eff < 10'd300);

    logic [1:0] act_sig, act_on;
    assign act_sig = {rx_s, tx_s};

    for (genvar ch = 0; ch < 2; ch++) begin : g_str
        ebaz_led_stretch #(.STRETCH_MS(STRETCH_MS)) u_str (
            .clk    (clk),
            .rst_n  (rst_n),
            .sig    (act_sig[ch]),
            .ms_tick(ms_tick),
            .clr    (mode_chg),
            .active (act_on[ch])
        );
    end

    logic pwm_on;
`ifdef EBAZ_LED_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 8'd1;
    end

    assign pwm_on = (pwm_cnt < sync2[13:6]);
`else
    assign pwm_on = 1'b1;
`endif

    logic red_on, green_on;

    always_comb begin
        red_on   = 1'b0;
        green_on = 1'b0;
        case (mode_s)
            M_PASS: begin
                red_on   = led_s[0];
                green_on = led_s[1];
            end
            M_ACT: begin
                red_on   = act_on[0];
                green_on = act_on[1];
            end
            M_HEART: green_on = hb_on;
            default: ;
        endcase
        red_on   = red_on & pwm_on;
        green_on = green_on & pwm_on;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_red   <= INV;
            led_green <= INV;
        end else begin
            led_red   <= red_on ^ INV;
            led_green <= green_on ^ INV;
        end
    end
endmodule

// File: tb/tb_ebaz_led_ctrl.sv
// Directed bench for ebaz_led_ctrl at 10 clk per ms, active-high and active-low instances.
module tb_ebaz_led_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] gpio_led, gpio_mode;
    logic       mii_tx_en, mii_rx_dv;
    logic       led_red, led_green, red_n, green_n;
`ifdef EBAZ_LED_PWM_EN
    logic [7:0] pwm_duty;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ebaz_led_ctrl #(.CLK_HZ(10000), .STRETCH_MS(5), .LED_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .gpio_led(gpio_led), .gpio_mode(gpio_mode),
        .mii_tx_en(mii_tx_en), .mii_rx_dv(mii_rx_dv),
`ifdef EBAZ_LED_PWM_EN
        .pwm_duty(pwm_duty),
`endif
        .led_red(led_red), .led_green(led_green)
    );

    ebaz_led_ctrl #(.CLK_HZ(10000), .STRETCH_MS(5), .LED_ACTIVE_LOW(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .gpio_led(gpio_led), .gpio_mode(gpio_mode),
        .mii_tx_en(mii_tx_en), .mii_rx_dv(mii_rx_dv),
`ifdef EBAZ_LED_PWM_EN
        .pwm_duty(pwm_duty),
`endif
        .led_red(red_n), .led_green(green_n)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // exp is {red, green} for the active-high instance; the other must be its inverse.
    task automatic chk(input string tag, input logic [1:0] exp);
        checks++;
        assert ({led_red, led_green} === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, {led_red, led_green}, exp);
        end
        checks++;
        assert ({red_n, green_n} === ~exp) else begin
            errors++;
            $error("FAIL %s_inv: observed %b expected %b", tag, {red_n, green_n}, ~exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; gpio_led = 2'b00; gpio_mode = 2'b00;
        mii_tx_en = 1'b0; mii_rx_dv = 1'b0;
`ifdef EBAZ_LED_PWM_EN
        pwm_duty = 8'd0;
`endif
        tick(3);
        chk("reset", 2'b00);
        rst_n = 1'b1;
        tick(5);
        chk("pass_idle", 2'b00);

`ifdef EBAZ_LED_PWM_EN
        begin
            int nr, ng;
            gpio_led = 2'b11; pwm_duty = 8'd64;
            tick(6);
            nr = 0; ng = 0;
            for (int i = 0; i < 256; i++) begin
                tick(1);
                nr += int'(led_red);
                ng += int'(led_green);
            end
            chk_int("pwm64_red", nr, 64);
            chk_int("pwm64_green", ng, 64);
            pwm_duty = 8'd0;
            tick(6);
            nr = 0; ng = 0;
            for (int i = 0; i < 256; i++) begin
                tick(1);
                nr += int'(led_red);
                ng += int'(led_green);
            end
            chk_int("pwm0_red", nr, 0);
            chk_int("pwm0_green", ng, 0);
        end
`else
        // PASS latency: output changes on the 3rd edge after the input
        gpio_led = 2'b01;
        tick(2); chk("pass_lat2", 2'b00);
        tick(1); chk("pass_lat3", 2'b10);
        gpio_led = 2'b10;
        tick(3); chk("pass_green", 2'b01);
        gpio_led = 2'b11;
        tick(3); chk("pass_both", 2'b11);
        gpio_mode = 2'b11;
        tick(3); chk("off", 2'b00);

        // ACT: single tx pulse stretched for 5 ms ticks
        gpio_led = 2'b00; gpio_mode = 2'b01;
        tick(6); chk("act_idle", 2'b00);
        mii_tx_en = 1'b1; tick(1);
        mii_tx_en = 1'b0; tick(1);
        chk("tx_lat2", 2'b00);
        tick(1);  chk("tx_on", 2'b10);
        tick(37); chk("tx_hold", 2'b10);
        tick(15); chk("tx_off", 2'b00);

        // ACT: rx pulses every 30 clk keep green solid
        for (int i = 0; i < 240; i++) begin
            mii_rx_dv = (i % 30 == 0) && (i <= 180);
            tick(1);
            if (i + 1 >= 3 && i + 1 <= 223) chk("rx_hold", 2'b01);
            if (i + 1 >= 235) chk("rx_off", 2'b00);
        end

        // Stretch counters clear on mode change
        mii_tx_en = 1'b1; tick(1);
        mii_tx_en = 1'b0; tick(10);
        chk("clr_pre", 2'b10);
        gpio_mode = 2'b00;
        tick(3); chk("clr_pass", 2'b00);
        gpio_mode = 2'b01;
        tick(3); chk("clr_act", 2'b00);

        // ACT -> HEART with stretch active; heartbeat restarts at ms 0
        mii_tx_en = 1'b1; tick(1);
        mii_tx_en = 1'b0; tick(10);
        chk("sw_pre", 2'b10);
        gpio_mode = 2'b10;
        tick(2);    chk("sw_lat2", 2'b10);
        tick(1);    chk("hb_start", 2'b01);
        tick(987);  chk("hb_on1_end", 2'b01);
        tick(25);   chk("hb_off1", 2'b00);
        tick(975);  chk("hb_off1_end", 2'b00);
        tick(25);   chk("hb_on2", 2'b01);
        tick(975);  chk("hb_on2_end", 2'b01);
        tick(25);   chk("hb_off2", 2'b00);
        tick(6975); chk("hb_off2_end", 2'b00);
        tick(25);   chk("hb_wrap", 2'b01);

        // Reset asserted mid-operation acts immediately; PASS resumes after sync
        gpio_mode = 2'b00; gpio_led = 2'b11;
        tick(4); chk("pre_rst", 2'b11);
        #3 rst_n = 1'b0;
        #1 chk("rst_async", 2'b00);
        #1 rst_n = 1'b1;
        tick(2); chk("rst_lat2", 2'b00);
        tick(1); chk("rst_lat3", 2'b11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
